rtc_bus_writer: RTL

- Transmit side of the external RTC parallel bus: writes user-edited time, date and timer values from the register bank into the RTC chip.
- Uses the multiplexed address/data protocol: address phase, then data phase, per register.
- Sits between the register bank's RTC-facing outputs and the RTC pins. It is the write counterpart of the RTC read path that feeds the register bank.
- Each group write ends with a commit transaction that tells the chip to transfer the written registers.

---
 rtl/rtc_bus_pkg.sv | 42 ++++
 rtl/rtc_bus_writer_timer.sv | 31 +++
 rtl/rtc_bus_writer.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/rtc_bus_pkg.sv
// rtc_bus_pkg: shared definitions for the RTC parallel-bus writer and reader.
//   - RTC register addresses for the clock, date and timer groups
//   - default commit command address/data
//   - bus FSM state encoding and the group enum
package rtc_bus_pkg;

  localparam logic [7:0] ADDR_SEG_HORA   = 8'h21;
  localparam logic [7:0] ADDR_MIN_HORA   = 8'h22;
  localparam logic [7:0] ADDR_HORA_HORA  = 8'h23;
  localparam logic [7:0] ADDR_DIA_FECHA  = 8'h24;
  localparam logic [7:0] ADDR_MES_FECHA  = 8'h25;
  localparam logic [7:0] ADDR_JAHR_FECHA = 8'h26;
  localparam logic [7:0] ADDR_DIA_SEMANA = 8'h27;
  localparam logic [7:0] ADDR_SEG_TIMER  = 8'h41;
  localparam logic [7:0] ADDR_MIN_TIMER  = 8'h42;
  localparam logic [7:0] ADDR_HORA_TIMER = 8'h43;

  localparam logic [7:0] CMD_ADDR_DFLT   = 8'hF0;
  localparam logic [7:0] CMD_DATA_DFLT   = 8'hF1;

  // Longest list: four date registers plus the commit transaction.
  localparam int MAX_ITEMS = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_A_LO,
    ST_A_HI,
    ST_D_LO,
    ST_D_HI,
    ST_GAP,
    ST_DONE
  } state_t;

  // Values double as bit positions in the pending vector.
  typedef enum logic [1:0] {
    G_HORA  = 2'd0,
    G_FECHA = 2'd1,
    G_TIMER = 2'd2
  } group_t;

endpackage

// File: rtl/rtc_bus_writer_timer.sv
// rtc_phase_timer: loadable down-counter with terminal-count flag.
//   clk, reset : clock, async active-high reset
//   load       : load value into the counter this cycle
//   value      : phase length in cycles (>= 1)
//   tc         : high during the last cycle of the loaded phase (count == 1)
// The counter holds at 1 once it gets there, so tc stays high until reloaded.
module rtc_phase_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         tc
);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (count > W'(1)) begin
      count <= count - W'(1);
    end
  end

  assign tc = (count == W'(1));

endmodule

// File: rtl/rtc_bus_writer.sv
// rtc_bus_writer: writes clock/date/timer register groups into the external
// RTC over the multiplexed address/data bus, ending every group with a
// commit transaction.
//   clk, reset            : clock, async active-high reset
//   start_hora/fecha/timer: one-cycle requests, latched as pending bits
//   *_hora, *_fecha, dia_semana, *_timer : BCD source values
//   ad_out, ad_oe         : AD pad data and tristate enable
//   cs_n, wr_n, rd_n, a_d : bus control (rd_n tied high)
//   busy, done            : group in progress / one-cycle group completion
module rtc_bus_writer
  import rtc_bus_pkg::*;
#(
  parameter int unsigned T_PULSE  = 4,
  parameter int unsigned T_GAP    = 2,
  parameter logic [7:0]  CMD_ADDR = CMD_ADDR_DFLT,
  parameter logic [7:0]  CMD_DATA = CMD_DATA_DFLT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_hora,
  input  logic       start_fecha,
  input  logic       start_timer,
  input  logic [7:0] seg_hora,
  input  logic [7:0] min_hora,
  input  logic [7:0] hora_hora,
  input  logic [7:0] dia_fecha,
  input  logic [7:0] mes_fecha,
  input  logic [7:0] jahr_fecha,
  input  logic [7:0] dia_semana,
  input  logic [7:0] seg_timer,
  input  logic [7:0] min_timer,
  input  logic [7:0] hora_timer,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  output logic       cs_n,
  output logic       wr_n,
  output logic       rd_n,
  output logic       a_d,
  output logic       busy,
  output logic       done
);

  localparam int unsigned T_MAX = (T_PULSE > T_GAP) ? T_PULSE : T_GAP;
  localparam int          TW    = $clog2(T_MAX + 1);

  state_t       state;
  group_t       sel;
  logic [2:0]   pending;
  logic [2:0]   clr_mask;
  logic [2:0]   start_vec;
  logic [2:0]   idx;
  logic [2:0]   last;
  logic [2:0]   load_last;
  logic [7:0]   snap_addr [MAX_ITEMS];
  logic [7:0]   snap_data [MAX_ITEMS];
  logic [7:0]   load_addr [MAX_ITEMS];
  logic [7:0]   load_data [MAX_ITEMS];
  logic         tmr_load;
  logic [TW-1:0] tmr_val;
  logic         tc;

  assign start_vec = {start_timer, start_fecha, start_hora};
  assign rd_n      = 1'b1;

  // Fixed priority: hora > fecha > timer.
  always_comb begin
    if (pending[0])      sel = G_HORA;
    else if (pending[1]) sel = G_FECHA;
    else                 sel = G_TIMER;
  end

  always_comb begin
    clr_mask = 3'b000;
    if (state == ST_LOAD) begin
      case (sel)
        G_HORA:  clr_mask = 3'b001;
        G_FECHA: clr_mask = 3'b010;
        default: clr_mask = 3'b100;
      endcase
    end
  end

  // A new request in the same cycle its bit is cleared wins, so it is
  // served again after the current transfer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending <= 3'b000;
    end else begin
      pending <= (pending & ~clr_mask) | start_vec;
    end
  end

  // Transaction list for the selected group, commit always last.
  always_comb begin
    for (int i = 0; i < MAX_ITEMS; i++) begin
      load_addr[i] = 8'h00;
      load_data[i] = 8'h00;
    end
    load_last = 3'd3;
    case (sel)
      G_HORA: begin
        load_addr[0] = ADDR_SEG_HORA;   load_data[0] = seg_hora;
        load_addr[1] = ADDR_MIN_HORA;   load_data[1] = min_hora;
        load_addr[2] = ADDR_HORA_HORA;  load_data[2] = hora_hora;
        load_addr[3] = CMD_ADDR;        load_data[3] = CMD_DATA;
      end
      G_FECHA: begin
        load_addr[0] = ADDR_DIA_FECHA;  load_data[0] = dia_fecha;
        load_addr[1] = ADDR_MES_FECHA;  load_data[1] = mes_fecha;
        load_addr[2] = ADDR_JAHR_FECHA; load_data[2] = jahr_fecha;
        load_addr[3] = ADDR_DIA_SEMANA; load_data[3] = dia_semana;
        load_addr[4] = CMD_ADDR;        load_data[4] = CMD_DATA;
        load_last    = 3'd4;
      end
      default: begin
        load_addr[0] = ADDR_SEG_TIMER;  load_data[0] = seg_timer;
        load_addr[1] = ADDR_MIN_TIMER;  load_data[1] = min_timer;
        load_addr[2] = ADDR_HORA_TIMER; load_data[2] = hora_timer;
        load_addr[3] = CMD_ADDR;        load_data[3] = CMD_DATA;
      end
    endcase
  end

  // The timer reloads on every timed-state entry; only the GAP entry
  // (leaving D_HI) uses the gap length.
  always_comb begin
    tmr_load = (state == ST_LOAD) ||
               (tc && (state == ST_A_LO || state == ST_A_HI ||
                       state == ST_D_LO || state == ST_D_HI || state == ST_GAP));
    tmr_val  = (state == ST_D_HI) ? TW'(T_GAP) : TW'(T_PULSE);
  end

  rtc_phase_timer #(.W(TW)) u_timer (
    .clk   (clk),
    .reset (reset),
    .load  (tmr_load),
    .value (tmr_val),
    .tc    (tc)
  );

  // Outputs are assigned on the transition into each state so they are
  // registered and valid for the whole state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ST_IDLE;
      idx    <= 3'd0;
      last   <= 3'd0;
      cs_n   <= 1'b1;
      wr_n   <= 1'b1;
      a_d    <= 1'b0;
      ad_oe  <= 1'b0;
      ad_out <= 8'h00;
      busy   <= 1'b0;
      done   <= 1'b0;
      for (int i = 0; i < MAX_ITEMS; i++) begin
        snap_addr[i] <= 8'h00;
        snap_data[i] <= 8'h00;
      end
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (pending != 3'b000) state <= ST_LOAD;
        end
        ST_LOAD: begin
          for (int i = 0; i < MAX_ITEMS; i++) begin
            snap_addr[i] <= load_addr[i];
            snap_data[i] <= load_data[i];
          end
          last   <= load_last;
          idx    <= 3'd0;
          busy   <= 1'b1;
          cs_n   <= 1'b0;
          a_d    <= 1'b0;
          ad_oe  <= 1'b1;
          ad_out <= load_addr[0];
          wr_n   <= 1'b0;
          state  <= ST_A_LO;
        end
        ST_A_LO: begin
          if (tc) begin
            wr_n  <= 1'b1;
            state <= ST_A_HI;
          end
        end
        ST_A_HI: begin
          // Address-to-data switch lands on the same edge wr_n falls.
          if (tc) begin
            a_d    <= 1'b1;
            ad_out <= snap_data[idx];
            wr_n   <= 1'b0;
            state  <= ST_D_LO;
          end
        end
        ST_D_LO: begin
          if (tc) begin
            wr_n  <= 1'b1;
            state <= ST_D_HI;
          end
        end
        ST_D_HI: begin
          if (tc) begin
            cs_n   <= 1'b1;
            ad_oe  <= 1'b0;
            a_d    <= 1'b0;
            ad_out <= 8'h00;
            state  <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (tc) begin
            if (idx == last) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= ST_DONE;
            end else begin
              idx    <= idx + 3'd1;
              cs_n   <= 1'b0;
              ad_oe  <= 1'b1;
              ad_out <= snap_addr[idx + 3'd1];
              wr_n   <= 1'b0;
              state  <= ST_A_LO;
            end
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
